// File: rtl/cl_tap_capture.sv
// Camera Link tap capture: tags each captured pixel beat with frame,
// line and clock counters under control of host START/STOP/ABORT commands.
module cl_tap_capture #(
    parameter int N_TAPS         = 8,
    parameter int TAP_W          = 10,
    parameter int FRAME_NUM_SIZE = 20,
    parameter int LINE_NUM_SIZE  = 12,
    parameter int CLK_COUNT_SIZE = 12,
    localparam int DATA_W = N_TAPS * TAP_W,
    localparam int MSG_W  = FRAME_NUM_SIZE + LINE_NUM_SIZE + CLK_COUNT_SIZE + DATA_W
) (
    input  logic              cl_clk,
    input  logic              reset,
    input  logic              pc_msg_pending,
    input  logic [31:0]       pc_msg,
    output logic              pc_msg_ack,
    input  logic              cl_fval,
    input  logic              cl_lval,
    input  logic [DATA_W-1:0] cl_data,
    input  logic              fpga_msg_overflow,
    output logic [MSG_W-1:0]  fpga_msg,
    output logic              fpga_msg_valid,
    output logic [15:0]       dropped_beats,
    output logic [3:0]        led
);

    typedef enum logic [1:0] {
        STANDBY   = 2'd0,
        ARMED     = 2'd1,
        CAPTURING = 2'd2,
        STOPPING  = 2'd3
    } state_t;

    localparam logic [3:0] OP_START = 4'd1;
    localparam logic [3:0] OP_STOP  = 4'd2;
    localparam logic [3:0] OP_ABORT = 4'd3;

    state_t state, edge_state, next_state;

    logic                      fval_d, lval_d;
    logic                      fval_rise, fval_fall, lval_rise, lval_fall;
    logic [FRAME_NUM_SIZE-1:0] frame_num, cur_frame;
    logic [LINE_NUM_SIZE-1:0]  line_num, cur_line;
    logic [CLK_COUNT_SIZE-1:0] clk_count, cur_clk;
    logic [15:0]               frames_left;
    logic                      overflow_sticky;
    logic                      cmd, abort_cmd, start_ok;
    logic [3:0]                opcode;
    logic                      capture, beat;
    logic                      unused_msg_bits;

    assign unused_msg_bits = ^pc_msg[15:4];

    assign fval_rise = cl_fval & ~fval_d;
    assign fval_fall = ~cl_fval & fval_d;
    assign lval_rise = cl_lval & ~lval_d;
    assign lval_fall = ~cl_lval & lval_d;

    assign opcode    = pc_msg[3:0];
    assign cmd       = pc_msg_pending & ~pc_msg_ack;
    assign abort_cmd = cmd & (opcode == OP_ABORT);
    assign start_ok  = cmd & (opcode == OP_START) & (state == STANDBY);

    // Counter values as seen by a beat sampled this cycle (edges applied)
    assign cur_frame = fval_rise ? frame_num + FRAME_NUM_SIZE'(1) : frame_num;
    assign cur_line  = fval_rise ? '0 : line_num;
    assign cur_clk   = (fval_rise | lval_rise) ? '0 : clk_count;

    assign led = {overflow_sticky, state == CAPTURING, state == ARMED, frame_num[0]};

    // Edge history and frame/line/clock counters, free-running in every state
    always_ff @(posedge cl_clk) begin
        if (reset) begin
            fval_d    <= 1'b0;
            lval_d    <= 1'b0;
            frame_num <= '0;
            line_num  <= '0;
            clk_count <= '0;
        end else begin
            fval_d    <= cl_fval;
            lval_d    <= cl_lval;
            frame_num <= cur_frame;
            line_num  <= (lval_fall & cl_fval) ? cur_line + LINE_NUM_SIZE'(1) : cur_line;
            clk_count <= (cl_fval & cl_lval) ? cur_clk + CLK_COUNT_SIZE'(1) : cur_clk;
        end
    end

    // Frame-edge transitions first, then host command on the pre-command state
    always_comb begin
        edge_state = state;
        next_state = state;
        unique case (state)
            ARMED:     if (fval_rise) edge_state = CAPTURING;
            CAPTURING: if (fval_fall && frames_left == 16'd1) edge_state = STANDBY;
            STOPPING:  if (fval_fall) edge_state = STANDBY;
            default:   edge_state = state;
        endcase
        next_state = edge_state;
        if (cmd) begin
            case (opcode)
                OP_START: if (state == STANDBY) next_state = ARMED;
                OP_STOP: begin
                    if (state == ARMED)
                        next_state = STANDBY;
                    else if (state == CAPTURING)
                        next_state = fval_fall ? STANDBY : STOPPING;
                end
                OP_ABORT: next_state = STANDBY;
                default:  next_state = edge_state;
            endcase
        end
    end

    // Beat qualification: capture states, or the frame start that arms capture
    always_comb begin
        capture = 1'b0;
        if (state == CAPTURING || state == STOPPING)
            capture = 1'b1;
        else if (state == ARMED && fval_rise && next_state == CAPTURING)
            capture = 1'b1;
        beat = capture & cl_fval & cl_lval & ~abort_cmd;
    end

    // State register
    always_ff @(posedge cl_clk) begin
        if (reset) state <= STANDBY;
        else       state <= next_state;
    end

    // Remaining frame budget; zero means run until stopped
    always_ff @(posedge cl_clk) begin
        if (reset)
            frames_left <= '0;
        else if (start_ok)
            frames_left <= pc_msg[31:16];
        else if (state == CAPTURING && fval_fall && !abort_cmd && frames_left > 16'd1)
            frames_left <= frames_left - 16'd1;
    end

    // One-cycle acknowledge for every pending command word
    always_ff @(posedge cl_clk) begin
        if (reset) pc_msg_ack <= 1'b0;
        else       pc_msg_ack <= cmd;
    end

    // Registered beat output, overflow drop accounting
    always_ff @(posedge cl_clk) begin
        if (reset) begin
            fpga_msg        <= '0;
            fpga_msg_valid  <= 1'b0;
            dropped_beats   <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            fpga_msg_valid <= beat & ~fpga_msg_overflow;
            if (beat && !fpga_msg_overflow)
                fpga_msg <= {cur_frame, cur_line, cur_clk, cl_data};
            if (beat && fpga_msg_overflow) begin
                overflow_sticky <= 1'b1;
                if (dropped_beats != 16'hFFFF)
                    dropped_beats <= dropped_beats + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cl_tap_capture.sv
// Directed bench for cl_tap_capture: frames are generated by the bench,
// expected beats are queued at drive time and matched on output.
module tb_cl_tap_capture;

    localparam int DATA_W = 80;
    localparam int MSG_W  = 124;
    localparam int LINES  = 4;
    localparam int CLKS   = 16;

    localparam logic [31:0] START2 = 32'h0002_0001;
    localparam logic [31:0] START0 = 32'h0000_0001;
    localparam logic [31:0] STOP   = 32'h0000_0002;
    localparam logic [31:0] ABORT  = 32'h0000_0003;
    localparam logic [31:0] BOGUS  = 32'h0005_0007;

    typedef struct {
        logic [MSG_W-1:0] msg;
        int               cyc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              pc_msg_pending;
    logic [31:0]       pc_msg;
    logic              pc_msg_ack;
    logic              cl_fval;
    logic              cl_lval;
    logic [DATA_W-1:0] cl_data;
    logic              fpga_msg_overflow;
    logic [MSG_W-1:0]  fpga_msg;
    logic              fpga_msg_valid;
    logic [15:0]       dropped_beats;
    logic [3:0]        led;

    exp_t q[$];
    int   n_chk;
    int   n_fail;
    int   n_valid;
    int   ncyc;
    int   tb_frame;
    int   v0;

    cl_tap_capture dut (
        .cl_clk            (clk),
        .reset             (reset),
        .pc_msg_pending    (pc_msg_pending),
        .pc_msg            (pc_msg),
        .pc_msg_ack        (pc_msg_ack),
        .cl_fval           (cl_fval),
        .cl_lval           (cl_lval),
        .cl_data           (cl_data),
        .fpga_msg_overflow (fpga_msg_overflow),
        .fpga_msg          (fpga_msg),
        .fpga_msg_valid    (fpga_msg_valid),
        .dropped_beats     (dropped_beats),
        .led               (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    // Advance one clock, then check handshake and scoreboard 1ns after the edge
    task automatic tick();
        logic p, a, r, exp_ack, exp_v;
        exp_t e;
        p = pc_msg_pending;
        a = pc_msg_ack;
        r = reset;
        @(posedge clk);
        #1;
        ncyc++;
        exp_ack = !r && p && !a;
        chk("ack", 128'(pc_msg_ack), 128'(exp_ack));
        exp_v = (q.size() > 0) && (q[0].cyc == ncyc);
        chk("valid", 128'(fpga_msg_valid), 128'(exp_v));
        if (fpga_msg_valid === 1'b1) n_valid++;
        if (exp_v) begin
            e = q.pop_front();
            if (fpga_msg_valid === 1'b1)
                chk("msg", 128'(fpga_msg), 128'(e.msg));
        end
        if (pc_msg_ack === 1'b1) pc_msg_pending = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] w);
        pc_msg = w;
        pc_msg_pending = 1'b1;
        for (int i = 0; i < 8 && pc_msg_pending; i++) tick();
        chk("cmd_acked", 128'(pc_msg_pending), 128'(1'b0));
        pc_msg_pending = 1'b0;
        tick();
    endtask

    // One frame of LINES x CLKS pixels; pixel index p selects capture window,
    // overflow window, in-frame command and in-frame reset
    task automatic send_frame(input bit lead, input int cap_from, input int cap_to,
                              input int ovf_at, input int ovf_len,
                              input int cmd_at, input logic [31:0] cmd,
                              input int rst_at);
        int p;
        logic [DATA_W-1:0] d;
        exp_t e;
        p = 0;
        tb_frame++;
        cl_fval = 1'b1;
        cl_lval = 1'b0;
        if (lead) tick();
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < CLKS; c++) begin
                d = DATA_W'({$urandom(), $urandom(), $urandom()});
                cl_lval = 1'b1;
                cl_data = d;
                fpga_msg_overflow = (p >= ovf_at) && (p < ovf_at + ovf_len);
                if (p == cmd_at) begin
                    pc_msg = cmd;
                    pc_msg_pending = 1'b1;
                end
                if (p == rst_at) begin
                    reset = 1'b1;
                    pc_msg = START0;
                    pc_msg_pending = 1'b1;
                    tb_frame = 1;
                end
                if (p >= cap_from && p < cap_to && !fpga_msg_overflow) begin
                    e.msg = {20'(tb_frame), 12'(l), 12'(c), d};
                    e.cyc = ncyc + 1;
                    q.push_back(e);
                end
                tick();
                if (p == rst_at) begin
                    chk("rst_msg", 128'(fpga_msg), 128'(0));
                    chk("rst_dropped", 128'(dropped_beats), 128'(0));
                    chk("rst_led", 128'(led), 128'(0));
                    reset = 1'b0;
                end
                p++;
            end
            cl_lval = 1'b0;
            fpga_msg_overflow = 1'b0;
            tick();
            tick();
        end
        cl_fval = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        n_valid = 0;
        ncyc = 0;
        tb_frame = 0;
        reset = 1'b1;
        pc_msg_pending = 1'b0;
        pc_msg = '0;
        cl_fval = 1'b0;
        cl_lval = 1'b0;
        cl_data = '0;
        fpga_msg_overflow = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_msg", 128'(fpga_msg), 128'(0));
        chk("reset_dropped", 128'(dropped_beats), 128'(0));
        chk("reset_led", 128'(led), 128'(0));
        reset = 1'b0;
        tick();

        // START count=2 during frame 1: frames 2 and 3 captured
        send_frame(1, 0, 0, -1, 0, 5, START2, -1);
        chk("led_armed_f1", 128'(led), 128'(4'b0011));
        v0 = n_valid;
        send_frame(0, 0, 1000, -1, 0, -1, '0, -1);
        chk("led_capt_f2", 128'(led), 128'(4'b0100));
        send_frame(1, 0, 1000, -1, 0, -1, '0, -1);
        chk("beats_count2", 128'(n_valid - v0), 128'(128));
        chk("led_standby_f3", 128'(led), 128'(4'b0001));
        send_frame(1, 0, 0, -1, 0, -1, '0, -1);
        chk("led_f4", 128'(led), 128'(4'b0000));

        // START count=0 mid-frame, then STOP mid-frame
        send_frame(1, 0, 0, -1, 0, 3, START0, -1);
        chk("led_armed_f5", 128'(led), 128'(4'b0011));
        v0 = n_valid;
        send_frame(1, 0, 1000, -1, 0, 20, STOP, -1);
        chk("beats_stop_frame", 128'(n_valid - v0), 128'(64));
        chk("led_standby_f6", 128'(led), 128'(4'b0000));
        v0 = n_valid;
        send_frame(1, 0, 0, -1, 0, -1, '0, -1);
        chk("beats_after_stop", 128'(n_valid - v0), 128'(0));

        // Overflow held for 5 pixel cycles
        send_cmd(START0);
        chk("led_armed_idle", 128'(led), 128'(4'b0011));
        v0 = n_valid;
        send_frame(1, 0, 1000, 20, 5, -1, '0, -1);
        chk("beats_overflow", 128'(n_valid - v0), 128'(59));
        chk("dropped_beats", 128'(dropped_beats), 128'(5));
        chk("led_overflow", 128'(led), 128'(4'b1100));

        // ABORT mid-line
        v0 = n_valid;
        send_frame(1, 0, 30, -1, 0, 30, ABORT, -1);
        chk("beats_abort", 128'(n_valid - v0), 128'(30));
        chk("led_abort", 128'(led), 128'(4'b1001));

        // Reset mid-frame with a command pending
        send_cmd(START0);
        send_frame(1, 0, 10, -1, 0, -1, '0, 10);
        chk("led_after_rst", 128'(led), 128'(4'b0011));
        send_frame(1, 0, 1000, -1, 0, -1, '0, -1);
        chk("led_capt_post_rst", 128'(led), 128'(4'b0100));

        // Unknown opcode is acked without effect, then ABORT while idle
        send_cmd(BOGUS);
        chk("led_bogus", 128'(led), 128'(4'b0100));
        send_cmd(ABORT);
        chk("led_final", 128'(led), 128'(4'b0000));
        chk("queue_empty", 128'(q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cl_tap_capture.md
CL_TAP_CAPTURE -- requirements
Module: cl_tap_capture

Interface
REQ-001 Parameter N_TAPS, default 8, number of Camera Link taps per clock.
REQ-002 Parameter TAP_W, default 10, bits per tap; DATA_W = N_TAPS*TAP_W.
REQ-003 Parameters FRAME_NUM_SIZE 20, LINE_NUM_SIZE 12, CLK_COUNT_SIZE 12: counter widths; MSG_W = FRAME_NUM_SIZE+LINE_NUM_SIZE+CLK_COUNT_SIZE+DATA_W.
REQ-004 Clocking and reset SHALL be: one clock, cl_clk; reset is synchronous and active-high.
REQ-005 cl_clk  in  1  pixel clock; sole clock, all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 pc_msg_pending  in  1  command available (already in cl_clk domain).
REQ-008 pc_msg  in  32  command word: [3:0] opcode, [31:16] frame count.
REQ-009 pc_msg_ack  out  1  one-cycle command acknowledge.
REQ-010 cl_fval, cl_lval  in  1 each  frame/line valid, sampled each cycle.
REQ-011 cl_data  in  DATA_W  tap data.
REQ-012 fpga_msg_overflow  in  1  downstream cannot accept a beat this cycle.
REQ-013 fpga_msg  out  MSG_W  {frame_num, line_num, clk_count, data}, MSB first.
REQ-014 fpga_msg_valid  out  1  fpga_msg holds a beat this cycle.
REQ-015 dropped_beats  out  16  saturating count of beats lost to overflow.
REQ-016 led  out  4  {overflow_sticky, state==CAPTURING, state==ARMED, frame_num[0]}.

Function
REQ-017 Edges SHALL be detected synchronously from registered fval_d/lval_d; fval_rise = cl_fval & ~fval_d, lval_rise/lval_fall likewise.
REQ-018 frame_num SHALL increment (wrapping) on every fval_rise in any state; line_num and clk_count clear to 0 on fval_rise.
REQ-019 line_num SHALL increment (wrapping) on each lval_fall while cl_fval=1; clk_count clears on lval_rise and increments (wrapping) per cycle with cl_fval&cl_lval.
REQ-020 States SHALL be STANDBY, ARMED, CAPTURING, STOPPING.
REQ-021 Command handshake: when pc_msg_pending & ~pc_msg_ack, assert pc_msg_ack for exactly one cycle; command takes effect that same edge; every opcode, including unknown, is acked.
REQ-022 Opcode 1 START: from STANDBY go ARMED, load frames_left = pc_msg[31:16] (0 = continuous); ignored in other states.
REQ-023 Opcode 2 STOP: CAPTURING -> STOPPING; ARMED -> STANDBY; else no effect.
REQ-024 Opcode 3 ABORT: any state -> STANDBY immediately; no further beats after the abort edge.
REQ-025 ARMED -> CAPTURING on fval_rise; frames captured only from a frame start, never mid-frame.
REQ-026 In CAPTURING on fval falling edge: if frames_left==1 go STANDBY; else decrement frames_left when nonzero and stay.
REQ-027 STOPPING -> STANDBY on fval falling edge; beats of the current frame are still emitted.
REQ-028 A beat SHALL be generated for each cycle with cl_fval&cl_lval in CAPTURING/STOPPING (including the fval_rise cycle that enters CAPTURING); fpga_msg/fpga_msg_valid registered, latency exactly 1 cycle, carrying the counter values of the sample cycle.
REQ-029 If fpga_msg_overflow=1 in a beat's sample cycle, that beat SHALL be dropped (valid stays 0), dropped_beats increments (saturate at 16'hFFFF), overflow_sticky sets.
REQ-030 Command and fval edge on the same cycle: command applied, edge-triggered transition evaluated against the pre-command state only if command is not ABORT.

Reset
REQ-031 On reset: state STANDBY, pc_msg_ack 0, fpga_msg_valid 0, fpga_msg 0, all counters, frames_left, dropped_beats, overflow_sticky 0, fval_d/lval_d 0.
REQ-032 Reset mid-frame SHALL suppress all beats until a new START and a new fval_rise.

Verification
REQ-033 START count=2, three frames of 4 lines x 16 clocks -> beats only for frames 2..3 of capture (128 beats), frame_num increments 1,2,3, return to STANDBY.
REQ-034 START count=0, STOP mid-frame -> remaining beats of that frame emitted, STANDBY at fval fall, no beats next frame.
REQ-035 ABORT mid-line -> fpga_msg_valid 0 from next cycle; ack high exactly 1 cycle.
REQ-036 fpga_msg_overflow held 5 cycles during a line -> 5 beats missing, dropped_beats=5, led[3]=1.
REQ-037 START issued while cl_fval=1 -> no beats until next fval_rise; first beat line_num=0, clk_count=0.
REQ-038 Reset asserted mid-frame with pending=1 -> all outputs 0 next edge; ack pulses once after reset deasserts.
